pipe_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the front of the 19-bit pipeline.
- Drives the PC write enable, the IF/ID write and flush controls, and the ID/EX write and flush controls from hazard inputs:
  - load-use hazards
  - taken branches resolved in EX
  - multi-cycle EX operations
  - HALT decode
- Holds a small FSM (RUN / MC_WAIT / HALTED) and a saturating stall-cycle performance counter.

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/load_use_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the front-end pipeline control blocks.
// Holds the controller state encoding and the default geometry constants.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMcWait = 2'd1,
    StHalted = 2'd2
  } ctrl_state_e;

  localparam int unsigned RegAwDefault    = 3;
  localparam int unsigned McCyclesDefault = 4;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load destination.
// Register 0 is compared like any other register.
module load_use_detect
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = RegAwDefault
) (
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              load_use_o
);

  always_comb begin
    load_use_o = ex_memread_i & ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                                 (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard/sequencing controller: PC and IF/ID, ID/EX write/flush enables,
// RUN/MC_WAIT/HALTED sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW    = RegAwDefault,
  parameter int unsigned MC_CYCLES = McCyclesDefault,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic              ID_rs1_used,
  input  logic              ID_rs2_used,
  input  logic              ID_halt,
  input  logic              EX_memread,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic              EX_branch_taken,
  input  logic              EX_mc_start,
  input  logic              resume,
  output logic              PCwrite,
  output logic              IF_IDwrite,
  output logic              IF_IDflush,
  output logic              ID_EXwrite,
  output logic              ID_EXflush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned     McW    = $clog2(MC_CYCLES) + 1;
  localparam logic [McW-1:0]  McLoad = McW'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  ctrl_state_e      state_q, state_d;
  logic [McW-1:0]   mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic load_use;
  logic pc_we, ifid_we, ifid_fl, idex_we, idex_fl;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .id_rs1_i      (ID_rs1),
    .id_rs2_i      (ID_rs2),
    .id_rs1_used_i (ID_rs1_used),
    .id_rs2_used_i (ID_rs2_used),
    .ex_memread_i  (EX_memread),
    .ex_rd_i       (EX_rd),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_we  = 1'b1;
    idex_fl  = 1'b0;
    case (state_q)
      StRun: begin
        if (EX_branch_taken) begin
          ifid_fl = 1'b1;
          idex_fl = 1'b1;
        end else if (EX_mc_start) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_we  = 1'b0;
          mc_cnt_d = McLoad;
          state_d  = StMcWait;
        end else if (load_use) begin
          // One bubble into EX while PC and IF/ID hold the dependent instruction.
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          idex_fl = 1'b1;
        end else if (ID_halt) begin
          state_d = StHalted;
        end
      end
      StMcWait: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        mc_cnt_d = mc_cnt_q - McW'(1);
        if (mc_cnt_q == McW'(1)) begin
          state_d = StRun;
        end
      end
      StHalted: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
        if (resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    stall_d = stall_q;
    if ((state_q != StHalted) && !pc_we && (stall_q != CntMax)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      mc_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      stall_q  <= stall_d;
    end
  end

  // Reset forces the pipeline registers to hold bubbles regardless of state.
  always_comb begin
    PCwrite      = rst_n & pc_we;
    IF_IDwrite   = rst_n & ifid_we;
    IF_IDflush   = ~rst_n | ifid_fl;
    ID_EXwrite   = rst_n & idex_we;
    ID_EXflush   = ~rst_n | idex_fl;
    halted       = (state_q == StHalted);
    stall_cycles = stall_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, all compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW    = 3;
  localparam int unsigned MC_CYCLES = 4;
  localparam int unsigned CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REG_AW-1:0] ID_rs1, ID_rs2, EX_rd;
  logic              ID_rs1_used, ID_rs2_used, ID_halt;
  logic              EX_memread, EX_branch_taken, EX_mc_start, resume;
  logic              PCwrite, IF_IDwrite, IF_IDflush, ID_EXwrite, ID_EXflush, halted;
  logic [CNT_W-1:0]  stall_cycles;

  pipe_hazard_ctrl #(
    .REG_AW    (REG_AW),
    .MC_CYCLES (MC_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_rs1_used     (ID_rs1_used),
    .ID_rs2_used     (ID_rs2_used),
    .ID_halt         (ID_halt),
    .EX_memread      (EX_memread),
    .EX_rd           (EX_rd),
    .EX_branch_taken (EX_branch_taken),
    .EX_mc_start     (EX_mc_start),
    .resume          (resume),
    .PCwrite         (PCwrite),
    .IF_IDwrite      (IF_IDwrite),
    .IF_IDflush      (IF_IDflush),
    .ID_EXwrite      (ID_EXwrite),
    .ID_EXflush      (ID_EXflush),
    .halted          (halted),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 = running, 1 = frozen by multi-cycle op, 2 = halted.
  int m_mode   = 0;
  int m_left   = 0;
  int m_stalls = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hazard();
    return EX_memread && ((ID_rs1_used && ID_rs1 == EX_rd) || (ID_rs2_used && ID_rs2 == EX_rd));
  endfunction

  // {PCwrite, IF_IDwrite, IF_IDflush, ID_EXwrite, ID_EXflush, halted}
  function automatic logic [5:0] exp_ctrl();
    if (!rst_n) return 6'b001010;
    if (m_mode == 1) return 6'b000000;
    if (m_mode == 2) return 6'b001111;
    if (EX_branch_taken) return 6'b111110;
    if (EX_mc_start) return 6'b000000;
    if (hazard()) return 6'b000110;
    return 6'b110100;
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_left   = 0;
    m_stalls = 0;
  endtask

  task automatic model_clock();
    int max_cnt;
    max_cnt = (1 << CNT_W) - 1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: begin
        if (EX_branch_taken) begin
        end else if (EX_mc_start) begin
          m_stalls++;
          m_mode = 1;
          m_left = MC_CYCLES - 1;
        end else if (hazard()) begin
          m_stalls++;
        end else if (ID_halt) begin
          m_mode = 2;
        end
      end
      1: begin
        m_stalls++;
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
      default: if (resume) m_mode = 0;
    endcase
    if (m_stalls > max_cnt) m_stalls = max_cnt;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    #1;
    if (!rst_n) model_reset();
    check({tag, ".ctrl"},
          {26'd0, PCwrite, IF_IDwrite, IF_IDflush, ID_EXwrite, ID_EXflush, halted},
          {26'd0, exp_ctrl()});
    check({tag, ".stall"}, {{(32 - CNT_W){1'b0}}, stall_cycles}, m_stalls);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0;
    ID_rs1_used = 1'b0; ID_rs2_used = 1'b0; ID_halt = 1'b0;
    EX_memread = 1'b0; EX_branch_taken = 1'b0; EX_mc_start = 1'b0; resume = 1'b0;
  endtask

  task automatic set_load_use();
    EX_memread = 1'b1; EX_rd = 3'd3; ID_rs2 = 3'd3; ID_rs2_used = 1'b1;
  endtask

  initial begin
    int snap;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step("reset");
    rst_n = 1'b1;
    step("post_reset");
    check("post_reset.stall0", {16'd0, stall_cycles}, 32'd0);

    set_load_use();
    step("load_use");
    idle();
    step("after_load_use");
    check("load_use.count", {16'd0, stall_cycles}, 32'd1);

    snap = m_stalls;
    set_load_use(); ID_halt = 1'b1; EX_branch_taken = 1'b1;
    step("branch_wins");
    idle();
    step("branch_stays_run");
    check("branch.count", {16'd0, stall_cycles}, snap);

    snap = m_stalls;
    EX_mc_start = 1'b1;
    step("mc_start");
    idle();
    for (int i = 0; i < MC_CYCLES - 1; i++) step("mc_wait");
    step("mc_done");
    check("mc.count", {16'd0, stall_cycles}, snap + MC_CYCLES);

    ID_halt = 1'b1;
    step("halt_issue");
    idle();
    snap = m_stalls;
    for (int i = 0; i < 5; i++) step("halted");
    check("halt.count", {16'd0, stall_cycles}, snap);
    resume = 1'b1;
    step("resume_cycle");
    idle();
    step("resumed");

    EX_mc_start = 1'b1;
    step("mc2_start");
    idle();
    step("mc2_wait1");
    rst_n = 1'b0;
    step("mc2_reset");
    rst_n = 1'b1;
    step("mc2_post_reset");
    check("mc2.count", {16'd0, stall_cycles}, 32'd0);

    for (int i = 0; i < 800; i++) begin
      ID_rs1          = REG_AW'($urandom_range(0, 3));
      ID_rs2          = REG_AW'($urandom_range(0, 3));
      EX_rd           = REG_AW'($urandom_range(0, 3));
      ID_rs1_used     = 1'($urandom_range(0, 1));
      ID_rs2_used     = 1'($urandom_range(0, 1));
      EX_memread      = ($urandom_range(0, 9) < 4);
      EX_branch_taken = ($urandom_range(0, 19) < 3);
      EX_mc_start     = ($urandom_range(0, 19) == 0);
      ID_halt         = ($urandom_range(0, 19) == 0);
      resume          = ($urandom_range(0, 4) == 0);
      rst_n           = ($urandom_range(0, 149) != 0);
      step("random");
    end
    rst_n = 1'b1;
    idle();
    step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
